// File: rtl/gpr_wr_arbiter.sv
// Round-robin arbiter sharing the single GPR write port among NUM_REQ buffered write sources.
// Optional R0 write filtering when GPR_WR_ARB_R0_FILTER_EN is defined.
module gpr_wr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int RSZ     = 32,
  parameter int GPR_ASZ = 5
) (
  input  logic                              clk_in,
  input  logic                              reset_n_in,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][GPR_ASZ-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][RSZ-1:0]       req_data,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic [NUM_REQ-1:0]                pend,
  output logic                              Rd_wr,
  output logic [GPR_ASZ-1:0]                Rd_addr,
  output logic [RSZ-1:0]                    Rd_data,
  output logic                              r0_drop
);

  localparam int          PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR = NUM_REQ;

  logic [NUM_REQ-1:0]              buf_v;
  logic [NUM_REQ-1:0][GPR_ASZ-1:0] buf_addr;
  logic [NUM_REQ-1:0][RSZ-1:0]     buf_data;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      gidx;
  logic [PW-1:0]      next_ptr;
  logic [NUM_REQ-1:0] grant;
  logic               any_grant;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] load;

  // Walk the buffers starting at rr_ptr; the first valid one wins.
  always_comb begin
    int unsigned sum;
    logic [PW-1:0] idx;
    grant     = '0;
    gidx      = '0;
    any_grant = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int unsigned off = 0; off < NR; off++) begin
      sum = 32'(rr_ptr) + off;
      if (sum >= NR) sum = sum - NR;
      idx = PW'(sum);
      if (!any_grant && buf_v[idx]) begin
        grant[idx] = 1'b1;
        gidx       = idx;
        any_grant  = 1'b1;
      end
    end
  end

  always_comb begin
    next_ptr = '0;
    if (32'(gidx) != NR - 1) next_ptr = gidx + PW'(1);
  end

  assign req_ready = {NUM_REQ{reset_n_in}} & (~buf_v | grant);
  assign accept    = req_valid & req_ready;
  assign pend      = buf_v;

`ifdef GPR_WR_ARB_R0_FILTER_EN
  logic [NUM_REQ-1:0] zero_addr;

  always_comb begin
    zero_addr = '0;
    for (int unsigned i = 0; i < NR; i++) zero_addr[i] = (req_addr[i] == '0);
  end

  // R0 writes complete their handshake but never occupy a buffer.
  assign load = accept & ~zero_addr;

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) r0_drop <= 1'b0;
    else             r0_drop <= |(accept & zero_addr);
  end
`else
  assign load    = accept;
  assign r0_drop = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!reset_n_in) begin
      buf_v   <= '0;
      rr_ptr  <= '0;
      Rd_wr   <= 1'b0;
      Rd_addr <= '0;
      Rd_data <= '0;
    end else begin
      // A refill on the drain edge keeps the buffer valid.
      buf_v <= (buf_v & ~grant) | load;
      Rd_wr <= any_grant;
      if (any_grant) begin
        Rd_addr <= buf_addr[gidx];
        Rd_data <= buf_data[gidx];
        rr_ptr  <= next_ptr;
      end
    end
  end

  // Payload only matters while buf_v is set, so it carries no reset.
  always_ff @(posedge clk_in) begin
    for (int unsigned i = 0; i < NR; i++) begin
      if (load[i]) begin
        buf_addr[i] <= req_addr[i];
        buf_data[i] <= req_data[i];
      end
    end
  end

endmodule

// File: tb/tb_gpr_wr_arbiter.sv
// Self-checking bench for gpr_wr_arbiter: queue-level reference model plus directed literal checks.
module tb_gpr_wr_arbiter;

  localparam int N = 3;
  localparam int W = 32;
  localparam int A = 5;
`ifdef GPR_WR_ARB_R0_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic                  clk_in = 1'b0;
  logic                  reset_n_in = 1'b0;
  logic [N-1:0]          req_valid = '0;
  logic [N-1:0][A-1:0]   req_addr = '0;
  logic [N-1:0][W-1:0]   req_data = '0;
  logic [N-1:0]          req_ready;
  logic [N-1:0]          pend;
  logic                  Rd_wr;
  logic [A-1:0]          Rd_addr;
  logic [W-1:0]          Rd_data;
  logic                  r0_drop;

  gpr_wr_arbiter #(.NUM_REQ(N), .RSZ(W), .GPR_ASZ(A)) dut (
    .clk_in    (clk_in),
    .reset_n_in(reset_n_in),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .pend      (pend),
    .Rd_wr     (Rd_wr),
    .Rd_addr   (Rd_addr),
    .Rd_data   (Rd_data),
    .r0_drop   (r0_drop)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: one slot per requester, a round-robin pointer, a register-file image.
  logic [N-1:0] mv;
  logic [A-1:0] ma [N];
  logic [W-1:0] md [N];
  int           mrr;
  logic         exp_wr;
  logic [A-1:0] exp_addr;
  logic [W-1:0] exp_data;
  logic         exp_drop;
  logic [W-1:0] gpr_m [32];
  bit           live = 1'b0;

  function automatic int grant_idx();
    for (int o = 0; o < N; o++) begin
      int j;
      j = (mrr + o) % N;
      if (mv[j]) return j;
    end
    return -1;
  endfunction

  always @(posedge clk_in) begin : model
    int k;
    logic [N-1:0] acc;
    logic drop;
    if (live && exp_wr) gpr_m[exp_addr] = exp_data;
    if (!reset_n_in) begin
      mv = '0; mrr = 0; exp_wr = 0; exp_addr = '0; exp_data = '0; exp_drop = 0;
      live = 1'b1;
    end else if (live) begin
      k = grant_idx();
      for (int i = 0; i < N; i++) acc[i] = req_valid[i] && (!mv[i] || k == i);
      if (k >= 0) begin
        exp_wr = 1; exp_addr = ma[k]; exp_data = md[k];
        mv[k] = 0; mrr = (k + 1) % N;
      end else begin
        exp_wr = 0;
      end
      drop = 0;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          if (FILT && req_addr[i] == '0) drop = 1;
          else begin mv[i] = 1; ma[i] = req_addr[i]; md[i] = req_data[i]; end
        end
      end
      exp_drop = drop;
    end
  end

  always @(negedge clk_in) begin : compare
    if (live) begin
      logic [N-1:0] er;
      int k;
      k = grant_idx();
      for (int i = 0; i < N; i++) er[i] = reset_n_in && (!mv[i] || k == i);
      chk("req_ready", req_ready, er);
      chk("pend", pend, mv);
      chk("Rd_wr", Rd_wr, exp_wr);
      chk("Rd_addr", Rd_addr, exp_addr);
      chk("Rd_data", Rd_data, exp_data);
      chk("r0_drop", r0_drop, exp_drop);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    req_valid = '0; req_addr = '0; req_data = '0;
  endtask

  task automatic put(input int i, input logic [A-1:0] a, input logic [W-1:0] d);
    req_valid[i] = 1'b1; req_addr[i] = a; req_data[i] = d;
  endtask

  initial begin
    idle();
    reset_n_in = 0;
    repeat (3) tick();
    @(negedge clk_in);
    chk("rst_ready", req_ready, 0);
    chk("rst_pend", pend, 0);
    chk("rst_wr", Rd_wr, 0);
    tick();
    reset_n_in = 1;
    @(negedge clk_in);
    chk("idle_ready", req_ready, 3'b111);

    // Single write from requester 1: two-edge latency, then visible in the register file.
    tick();
    put(1, 5'd5, 32'hDEADBEEF);
    tick();
    idle();
    @(negedge clk_in);
    chk("single_pend", pend, 3'b010);
    chk("single_wr0", Rd_wr, 0);
    tick();
    @(negedge clk_in);
    chk("single_wr", Rd_wr, 1);
    chk("single_addr", Rd_addr, 5);
    chk("single_data", Rd_data, 32'hDEADBEEF);
    tick();
    chk("single_gpr", gpr_m[5], 32'hDEADBEEF);

    // All three requesters continuously from rr_ptr=0, first handshake on the release edge.
    tick();
    reset_n_in = 0;
    tick();
    reset_n_in = 1;
    for (int i = 0; i < N; i++) put(i, 5'(i + 1), 32'hA0 + 32'(i));
    tick();
    @(negedge clk_in);
    chk("rr_ready0", req_ready, 3'b001);
    chk("rr_wr0", Rd_wr, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      @(negedge clk_in);
      chk("rr_wr", Rd_wr, 1);
      chk("rr_addr", Rd_addr, 64'((c % 3) + 1));
      chk("rr_ready", req_ready, 64'(1 << ((c + 1) % 3)));
    end
    idle();
    repeat (4) tick();

    // Same address from requesters 0 and 2: issued in grant order, last one wins.
    reset_n_in = 0;
    tick();
    reset_n_in = 1;
    put(0, 5'd7, 32'h11);
    put(2, 5'd7, 32'h22);
    tick();
    idle();
    tick();
    @(negedge clk_in);
    chk("same_addr1", Rd_addr, 7);
    chk("same_data1", Rd_data, 32'h11);
    tick();
    @(negedge clk_in);
    chk("same_data2", Rd_data, 32'h22);
    tick();
    chk("same_gpr", gpr_m[7], 32'h22);

    // Requester 0 streams 8 beats alone.
    for (int n = 0; n < 10; n++) begin
      if (n < 8) put(0, 5'(10 + n), 32'h100 + 32'(n));
      else idle();
      @(negedge clk_in);
      if (n < 8) chk("stream_ready", req_ready[0], 1);
      if (n >= 2) begin
        chk("stream_wr", Rd_wr, 1);
        chk("stream_data", Rd_data, 64'(32'h100 + 32'(n - 2)));
      end
      tick();
    end

    // Reset with buffered writes outstanding.
    for (int i = 0; i < N; i++) put(i, 5'(20 + i), 32'h300 + 32'(i));
    tick();
    idle();
    tick();
    reset_n_in = 0;
    @(negedge clk_in);
    chk("rstmid_ready", req_ready, 0);
    tick();
    reset_n_in = 1;
    @(negedge clk_in);
    chk("rstmid_pend", pend, 0);
    chk("rstmid_wr", Rd_wr, 0);
    chk("rstmid_data", Rd_data, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      @(negedge clk_in);
      chk("rstmid_nowr", Rd_wr, 0);
    end

    // Write to R0.
    tick();
    put(2, 5'd0, 32'h5);
    tick();
    idle();
    @(negedge clk_in);
`ifdef GPR_WR_ARB_R0_FILTER_EN
    chk("r0_pulse", r0_drop, 1);
    chk("r0_pend", pend, 0);
`else
    chk("r0_pulse", r0_drop, 0);
    chk("r0_pend", pend, 3'b100);
`endif
    tick();
    @(negedge clk_in);
`ifdef GPR_WR_ARB_R0_FILTER_EN
    chk("r0_pulse_end", r0_drop, 0);
    chk("r0_wr", Rd_wr, 0);
`else
    chk("r0_wr", Rd_wr, 1);
    chk("r0_addr", Rd_addr, 0);
    chk("r0_data", Rd_data, 32'h5);
`endif
    tick();
    put(0, 5'd0, 32'h1);
    put(1, 5'd0, 32'h2);
    tick();
    idle();
    repeat (3) tick();

    // Mixed traffic with a mid-run reset; checked by the model every cycle.
    for (int c = 0; c < 48; c++) begin
      logic [N-1:0] pat;
      pat = 3'((c * 5 + 3) % 8);
      reset_n_in = (c != 30);
      for (int i = 0; i < N; i++) begin
        req_valid[i] = pat[i];
        req_addr[i]  = 5'((c * 3 + i * 11) % 32);
        req_data[i]  = {16'(c), 16'(i)};
      end
      tick();
    end
    reset_n_in = 1;
    idle();
    repeat (5) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpr_wr_arbiter.md
# gpr_wr_arbiter

Shares the single GPR write port (Rd_wr / Rd_addr / Rd_data of the RBUS slave on the register file) among NUM_REQ independent write sources: WB stage, the load-return path and the debug module. Each source gets a one-entry holding buffer with a valid/ready handshake. A round-robin scheduler drains the buffers onto a registered write port, one write per clock. Sits between the pipeline's write sources and gpr.sv; its outputs drive the register file's RBUS master side directly.

## Interface
- NUM_REQ, 3, number of write requesters (2..8)
- RSZ, 32, register width (from cpu_params_pkg)
- GPR_ASZ, 5, GPR address width (from cpu_params_pkg)
- clk_in  in  1  core clock, all state updates on rising edge
- reset_n_in  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  requester i presents a write
- req_addr  in  NUM_REQ x GPR_ASZ  destination GPR per requester
- req_data  in  NUM_REQ x RSZ  write data per requester
- req_ready  out  NUM_REQ  requester i write accepted this edge when valid & ready
- pend  out  NUM_REQ  holding buffer i occupied
- Rd_wr  out  1  registered GPR write strobe
- Rd_addr  out  GPR_ASZ  registered GPR write address
- Rd_data  out  RSZ  registered GPR write data
- r0_drop  out  1  one-cycle pulse: an R0 write was discarded

## Operation
- Per requester: buffer buf_v[i], buf_addr[i], buf_data[i].
- req_ready[i] = reset_n_in & (!buf_v[i] | grant[i]). This is combinational from buffer state and grant only, never from req_valid.
- Grant: combinational, one-hot over buf_v. Search starts at index rr_ptr and wraps modulo NUM_REQ. The first set buf_v wins. grant = 0 when no buffer is valid.
- On an edge with grant[k] set:
  - Rd_wr<=1, Rd_addr<=buf_addr[k], Rd_data<=buf_data[k].
  - buf_v[k] clears unless it is refilled on the same edge.
  - rr_ptr <= (k+1) mod NUM_REQ.
- On an edge with no grant: Rd_wr<=0, and Rd_addr/Rd_data hold their values. rr_ptr holds.
- Capture: valid & ready loads the buffer. Simultaneous drain and refill of the same buffer is legal and yields back-to-back writes from that requester only if no other buffer is pending.
- Same address from several requesters: each write is issued in grant order, and the last granted write wins. There is no merging or reordering within a requester.
- Fairness: a valid buffer is granted within NUM_REQ-1 cycles of becoming valid.
- Reset (reset_n_in=0 at an edge), also mid-operation:
  - buf_v=0, rr_ptr=0, Rd_wr=0, Rd_addr=0, Rd_data=0, r0_drop=0.
  - Buffered writes are discarded.
  - req_ready=0 while reset_n_in=0.
- req_addr/req_data X while req_valid=0 is legal. X while accepted is a requester error and is not masked.

## Timing
- Uncontested latency: handshake at edge t gives Rd_wr=1 in the cycle after edge t+1, i.e. 2 edges.
- Throughput: one write per cycle on the port; one write per cycle per requester when it is the only active source.
- Contested: the per-requester rate drops to 1/(number of active requesters).
- Rd_* outputs change only on clk_in rising edges. There are no combinational paths from req_* to Rd_*.
- The register file samples Rd_* on the following edge. The write is visible in gpr one cycle after Rd_wr is seen.
- First accepted handshake possible on the first edge with reset_n_in=1.

## Configuration
- Macro GPR_WR_ARB_R0_FILTER_EN, when defined:
  - An accepted request with req_addr==0 completes its handshake but is not loaded into the buffer.
  - r0_drop pulses for one cycle on the following cycle. If several requesters do this on one edge, only one pulse is produced.
  - Rd_wr is never asserted with Rd_addr==0.
- Undefined: R0 writes are treated as ordinary writes and forwarded. r0_drop is tied 0.

## Test plan
- Single requester 1 writes addr 5, data 0xDEADBEEF at edge t -> Rd_wr=1, Rd_addr=5, Rd_data=0xDEADBEEF after edge t+1; gpr[5]=0xDEADBEEF one cycle later.
- All 3 requesters valid continuously, rr_ptr=0 -> grant order 0,1,2,0,1,2; Rd_wr high every cycle; each req_ready high once per 3 cycles.
- Requesters 0 and 2 write addr 7 with 0x11 and 0x22 on the same edge, rr_ptr=0 -> two writes, 0x11 then 0x22; gpr[7]=0x22.
- Requester 0 streams 8 back-to-back writes alone -> req_ready stays 1, 8 consecutive Rd_wr cycles, data in order.
- Fill all buffers, then drop reset_n_in for 1 cycle -> pend=0, Rd_wr=0, req_ready=0 during reset; no buffered write appears afterward.
- With GPR_WR_ARB_R0_FILTER_EN: write addr 0 data 0x5 -> handshake completes, r0_drop=1 for one cycle, Rd_wr stays 0. Without the macro: Rd_wr=1, Rd_addr=0.
